// File: rtl/aes_inv_round_engine.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys
// fetched by index from an external key schedule, valid/ready on both sides.
module aes_inv_round_engine #(
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic [0:3]   key_idx,
  input  logic [0:127] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data
);

  localparam int NR = Nk + 6;
  localparam logic [3:0] NR4 = 4'(NR);

  // Only AES-128/192/256 key lengths have a defined schedule.
  generate
    if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_nk_check
      $error("aes_inv_round_engine: Nk must be 4, 6 or 8");
    end
  endgenerate

  // Inverse S-box, byte x at bits [8x +: 8] (left to right).
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  fsm_t         fsm_reg, fsm_next;
  logic [127:0] state_reg, state_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic [127:0] out_reg, out_next;
  logic         out_valid_reg, out_valid_next;

  logic [127:0] in_vec, key_vec, sub_bytes, added, mixed;

  // Internally byte i of the state lives at [127-8i -: 8].
  assign in_vec  = in_data;
  assign key_vec = key_in;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant k in GF(2^8).
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // InvShiftRows folded into the byte routing: row r rotates right by r.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub
      localparam int R   = gi % 4;
      localparam int C   = gi / 4;
      localparam int SRC = R + 4 * ((C - R + 4) % 4);
      assign sub_bytes[127-8*gi -: 8] =
        INV_SBOX[{state_reg[127-8*SRC -: 8], 3'b000} +: 8];
    end
  endgenerate

  assign added = sub_bytes ^ key_vec;

  // InvMixColumns on each column of the key-added state.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = added[127-32*gi -: 8];
      assign a1 = added[119-32*gi -: 8];
      assign a2 = added[111-32*gi -: 8];
      assign a3 = added[103-32*gi -: 8];
      assign mixed[127-32*gi -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      assign mixed[119-32*gi -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      assign mixed[111-32*gi -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      assign mixed[103-32*gi -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
  endgenerate

  // Next-state, datapath updates and key index decode.
  always_comb begin
    fsm_next       = fsm_reg;
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    out_next       = out_reg;
    out_valid_next = out_valid_reg;
    key_idx        = NR4;
    in_ready       = 1'b0;
    case (fsm_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = in_vec ^ key_vec;
          cnt_next   = NR4 - 4'd1;
          fsm_next   = ROUND;
        end
      end
      ROUND: begin
        key_idx    = cnt_reg;
        state_next = mixed;
        if (cnt_reg == 4'd1) begin
          cnt_next = 4'd0;
          fsm_next = FINAL;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      FINAL: begin
        key_idx        = 4'd0;
        out_next       = added;
        out_valid_next = 1'b1;
        fsm_next       = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          fsm_next       = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  // State registers; reset aborts any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      cnt_reg       <= NR4;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      fsm_reg       <= fsm_next;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_reg;

endmodule
